// File: rtl/up_mem_io.sv
// up_mem_io: memory and I/O slave for the up core.
// A multiplexed address is latched on ale. The slave serves a RAM window and
// an I/O window: NGPO output registers, a FIFO-buffered UART TX channel with
// its launch FSM, STATUS/CTRL registers and a level TX-idle interrupt.
//
// Ports:
//   clk, nRst      clock, asynchronous active-low reset
//   ale            latch wdata[AW-1:0] as the address
//   wdata          address (with ale) or write data (with we)
//   we, re         write / read at the previously latched address
//   rdata          registered read data, valid one cycle after re
//   gpo            output registers, reg k at [k*DW +: DW]
//   uart_busy      UART transmitter busy
//   uart_data      byte handed to the UART
//   uart_transmit  one-cycle launch strobe to the UART
//   irq            TX-idle interrupt (irq_en & idle), registered
module up_mem_io #(
    parameter int unsigned DW        = 8,
    parameter int unsigned AW        = 8,
    parameter int unsigned RAM_DEPTH = 192,
    parameter int unsigned IO_BASE   = 240,
    parameter int unsigned NGPO      = 2,
    parameter int unsigned TXF_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 nRst,
    input  logic                 ale,
    input  logic [DW-1:0]        wdata,
    input  logic                 we,
    input  logic                 re,
    output logic [DW-1:0]        rdata,
    output logic [NGPO*DW-1:0]   gpo,
    input  logic                 uart_busy,
    output logic [7:0]           uart_data,
    output logic                 uart_transmit,
    output logic                 irq
);

    localparam int unsigned PW  = $clog2(TXF_DEPTH);
    localparam int unsigned CW  = PW + 1;
    localparam int unsigned RAW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

    localparam logic [AW-1:0] RAM_END   = AW'(RAM_DEPTH);
    localparam logic [AW-1:0] IO_BASE_A = AW'(IO_BASE);
    localparam logic [AW-1:0] NGPO_A    = AW'(NGPO);
    localparam logic [AW-1:0] TXDATA_A  = AW'(IO_BASE + NGPO);
    localparam logic [AW-1:0] STATUS_A  = AW'(IO_BASE + NGPO + 1);
    localparam logic [AW-1:0] CTRL_A    = AW'(IO_BASE + NGPO + 2);
    localparam logic [CW-1:0] FIFO_FULL = CW'(TXF_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LAUNCH    = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } tx_state_e;

    // Storage without reset: RAM contents and FIFO payload
    logic [DW-1:0] mem_q [RAM_DEPTH];
    logic [7:0]    txf_q [TXF_DEPTH];

    logic [AW-1:0]      addr_q, addr_d;
    logic [DW-1:0]      rdata_q, rdata_d;
    logic [NGPO*DW-1:0] gpo_q, gpo_d;
    logic               irq_en_q, irq_en_d;
    logic               ovf_q, ovf_d;
    logic               irq_q, irq_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    tx_state_e          state_q, state_d;
    logic               wait_q, wait_d;
    logic [7:0]         uart_data_q, uart_data_d;
    logic               uart_tx_q, uart_tx_d;

    logic          ram_hit, gpo_hit, tx_hit, st_hit, ctrl_hit;
    logic [AW-1:0] gpo_off;
    logic          empty_c, full_c, idle_c;
    logic          push_req, push_ok, pop_c;
    logic [7:0]    head_c;
    logic [DW-1:0] status_c;
    logic [DW-1:0] rd_val;

    assign rdata         = rdata_q;
    assign gpo           = gpo_q;
    assign uart_data     = uart_data_q;
    assign uart_transmit = uart_tx_q;
    assign irq           = irq_q;

    // Address decode against the latched address
    always_comb begin
        gpo_off  = addr_q - IO_BASE_A;
        ram_hit  = (addr_q < RAM_END);
        gpo_hit  = (addr_q >= IO_BASE_A) && (gpo_off < NGPO_A);
        tx_hit   = (addr_q == TXDATA_A);
        st_hit   = (addr_q == STATUS_A);
        ctrl_hit = (addr_q == CTRL_A);
    end

    // FIFO flags and handshake; a full FIFO still accepts when a pop coincides
    always_comb begin
        empty_c  = (count_q == '0);
        full_c   = (count_q == FIFO_FULL);
        idle_c   = (state_q == S_IDLE) && empty_c;
        pop_c    = (state_q == S_LAUNCH);
        push_req = we && tx_hit;
        push_ok  = push_req && (!full_c || pop_c);
        head_c   = txf_q[rd_ptr_q];
        status_c = DW'({ovf_q, idle_c, empty_c, full_c});
    end

    // Read mux
    always_comb begin
        rd_val = '0;
        if (ram_hit) begin
            rd_val = mem_q[addr_q[RAW-1:0]];
        end else if (gpo_hit) begin
            for (int unsigned k = 0; k < NGPO; k++) begin
                if (gpo_off == AW'(k)) begin
                    rd_val = gpo_q[k*DW +: DW];
                end
            end
        end else if (st_hit) begin
            rd_val = status_c;
        end else if (ctrl_hit) begin
            rd_val = DW'(irq_en_q);
        end
    end

    // Register-file next state
    always_comb begin
        addr_d   = addr_q;
        rdata_d  = rdata_q;
        gpo_d    = gpo_q;
        irq_en_d = irq_en_q;
        ovf_d    = ovf_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (ale) begin
            addr_d = wdata[AW-1:0];
        end
        if (re) begin
            rdata_d = rd_val;
        end
        if (we && gpo_hit) begin
            for (int unsigned k = 0; k < NGPO; k++) begin
                if (gpo_off == AW'(k)) begin
                    gpo_d[k*DW +: DW] = wdata;
                end
            end
        end
        if (we && ctrl_hit) begin
            irq_en_d = wdata[0];
        end

        // A dropped push in the same cycle as a STATUS read keeps ovf set
        if (push_req && !push_ok) begin
            ovf_d = 1'b1;
        end else if (re && st_hit) begin
            ovf_d = 1'b0;
        end

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push_ok, pop_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    assign irq_d = irq_en_q && idle_c;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            addr_q   <= '0;
            rdata_q  <= '0;
            gpo_q    <= '0;
            irq_en_q <= 1'b0;
            ovf_q    <= 1'b0;
            irq_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            addr_q   <= addr_d;
            rdata_q  <= rdata_d;
            gpo_q    <= gpo_d;
            irq_en_q <= irq_en_d;
            ovf_q    <= ovf_d;
            irq_q    <= irq_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we && ram_hit) begin
            mem_q[addr_q[RAW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            txf_q[wr_ptr_q] <= wdata[7:0];
        end
    end

    // TX FSM: state register
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q     <= S_IDLE;
            wait_q      <= 1'b0;
            uart_data_q <= '0;
            uart_tx_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            uart_data_q <= uart_data_d;
            uart_tx_q   <= uart_tx_d;
        end
    end

    // TX FSM: next state; WAIT_BUSY gives up after two quiet cycles in case busy was missed
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            S_IDLE: begin
                if (!empty_c && !uart_busy) begin
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                state_d = S_WAIT_BUSY;
                wait_d  = 1'b0;
            end
            S_WAIT_BUSY: begin
                if (uart_busy) begin
                    state_d = S_WAIT_DONE;
                end else if (wait_q) begin
                    state_d = S_IDLE;
                end else begin
                    wait_d = 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (!uart_busy) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // TX FSM: outputs registered off the next state so the strobe spans exactly the LAUNCH cycle
    always_comb begin
        uart_tx_d   = (state_d == S_LAUNCH);
        uart_data_d = uart_data_q;
        if (state_d == S_LAUNCH) begin
            uart_data_d = head_c;
        end
    end

endmodule

// File: tb/tb_up_mem_io.sv
// tb_up_mem_io: directed self-checking bench for up_mem_io with a UART busy model.
module tb_up_mem_io;

    localparam logic [7:0] A_GPO0 = 8'hF0;
    localparam logic [7:0] A_GPO1 = 8'hF1;
    localparam logic [7:0] A_TX   = 8'hF2;
    localparam logic [7:0] A_ST   = 8'hF3;
    localparam logic [7:0] A_CTRL = 8'hF4;

    localparam logic [7:0] ST_FULL  = 8'h01;
    localparam logic [7:0] ST_EMPTY = 8'h02;
    localparam logic [7:0] ST_IDLE  = 8'h04;
    localparam logic [7:0] ST_OVF   = 8'h08;

    logic        clk;
    logic        nRst;
    logic        ale;
    logic [7:0]  wdata;
    logic        we;
    logic        re;
    logic [7:0]  rdata;
    logic [15:0] gpo;
    logic        uart_busy;
    logic [7:0]  uart_data;
    logic        uart_transmit;
    logic        irq;

    up_mem_io dut (
        .clk           (clk),
        .nRst          (nRst),
        .ale           (ale),
        .wdata         (wdata),
        .we            (we),
        .re            (re),
        .rdata         (rdata),
        .gpo           (gpo),
        .uart_busy     (uart_busy),
        .uart_data     (uart_data),
        .uart_transmit (uart_transmit),
        .irq           (irq)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // UART model state
    int         busy_len  = 10;
    bit         hold_busy = 1'b0;
    int         busy_cnt  = 0;
    logic [7:0] log_q[$];
    int         n_strobe  = 0;
    int         bad_busy  = 0;
    int         long_strb = 0;
    bit         prev_tx   = 1'b0;
    int         busy_fall = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // UART: busy for busy_len cycles after each strobe, or while hold_busy
    initial begin
        logic nb;
        uart_busy = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (uart_transmit) begin
                if (prev_tx) begin
                    long_strb++;
                end else begin
                    if (uart_busy) bad_busy++;
                    log_q.push_back(uart_data);
                    n_strobe++;
                    busy_cnt = busy_len;
                end
            end
            prev_tx = uart_transmit;
            nb = hold_busy || (busy_cnt > 0);
            if (uart_busy && !nb) busy_fall = cyc;
            uart_busy = nb;
            if (busy_cnt > 0) busy_cnt--;
        end
    end

    function automatic logic [7:0] log_at(input int i);
        if (i < log_q.size()) return log_q[i];
        return 8'hxx;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input logic [7:0] a);
        ale = 1'b1;
        wdata = a;
        tick();
        ale = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        set_addr(a);
        we = 1'b1;
        wdata = d;
        tick();
        we = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] d);
        set_addr(a);
        re = 1'b1;
        tick();
        re = 1'b0;
        d = rdata;
    endtask

    task automatic wait_strobes(input int n, input int bound);
        for (int i = 0; i < bound && n_strobe < n; i++) tick();
        check("tx_strobes", n_strobe, n);
    endtask

    task automatic wait_idle(input int bound);
        logic [7:0] s;
        bit done;
        s = 8'h00;
        done = 1'b0;
        for (int i = 0; i < bound && !done; i++) begin
            rd(A_ST, s);
            done = s[2];
        end
        check("wait_idle", 32'(done), 32'd1);
    endtask

    initial begin
        logic [7:0] v;
        int n0;
        bit seen;

        nRst = 1'b0; ale = 1'b0; wdata = 8'h00; we = 1'b0; re = 1'b0;
        repeat (3) @(posedge clk);
        #1 nRst = 1'b1;
        tick();

        // Reset state
        check("rst_rdata", rdata, 8'h00);
        check("rst_gpo", gpo, 16'h0000);
        check("rst_udata", uart_data, 8'h00);
        check("rst_utx", uart_transmit, 1'b0);
        check("rst_irq", irq, 1'b0);
        rd(A_ST, v);   check("rst_status", v, ST_IDLE | ST_EMPTY);
        rd(A_CTRL, v); check("rst_ctrl", v, 8'h00);
        rd(A_TX, v);   check("txdata_read", v, 8'h00);

        // RAM
        wr(8'h10, 8'hA5);
        rd(8'h10, v); check("ram_rd", v, 8'hA5);
        tick();       check("ram_hold", rdata, 8'hA5);
        wr(8'hBF, 8'h5A);
        rd(8'hBF, v); check("ram_top", v, 8'h5A);
        wr(8'hC0, 8'h33);
        rd(8'hC0, v); check("ram_end_unmapped", v, 8'h00);
        wr(8'hF7, 8'h77);
        rd(8'hF7, v); check("unmapped_f7", v, 8'h00);

        // ale with we in the same cycle writes at the old address
        wr(8'h21, 8'h99);
        set_addr(8'h20);
        ale = 1'b1; we = 1'b1; wdata = 8'h21;
        tick();
        ale = 1'b0; we = 1'b0;
        re = 1'b1;
        tick();
        re = 1'b0;
        check("ale_we_newaddr", rdata, 8'h99);
        rd(8'h20, v); check("ale_we_oldaddr", v, 8'h21);

        // GPO
        wr(A_GPO0, 8'h81);
        check("gpo0_wr", gpo, 16'h0081);
        wr(A_GPO1, 8'h3C);
        check("gpo1_wr", gpo, 16'h3C81);
        rd(A_GPO1, v); check("gpo1_rd", v, 8'h3C);
        rd(A_GPO0, v); check("gpo0_rd", v, 8'h81);

        // TX of two bytes
        wr(A_TX, 8'h41);
        wr(A_TX, 8'h42);
        wait_strobes(2, 200);
        check("tx_byte0", log_at(0), 8'h41);
        check("tx_byte1", log_at(1), 8'h42);
        check("tx_while_busy", bad_busy, 0);
        wait_idle(50);
        rd(A_ST, v); check("tx_status_idle", v, ST_IDLE | ST_EMPTY);
        check("tx_data_hold", uart_data, 8'h42);

        // Overflow with the UART held busy
        hold_busy = 1'b1;
        tick();
        n0 = n_strobe;
        for (int i = 0; i < 5; i++) wr(A_TX, 8'(8'h51 + i));
        rd(A_ST, v); check("ovf_status", v, ST_OVF | ST_FULL);
        rd(A_ST, v); check("ovf_cleared", v, ST_FULL);
        hold_busy = 1'b0;
        wait_strobes(n0 + 4, 400);
        wait_idle(50);
        repeat (20) tick();
        check("ovf_sent_cnt", n_strobe, n0 + 4);
        for (int i = 0; i < 4; i++) check("ovf_byte", log_at(n0 + i), 8'(8'h51 + i));

        // IRQ
        wr(A_CTRL, 8'hFF);
        rd(A_CTRL, v); check("ctrl_rd", v, 8'h01);
        tick();        check("irq_idle", irq, 1'b1);
        n0 = n_strobe;
        wr(A_TX, 8'h66);
        tick();        check("irq_fall", irq, 1'b0);
        wait_strobes(n0 + 1, 50);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            tick();
            seen = irq;
        end
        check("irq_rise", irq, 1'b1);
        check("irq_lag", cyc - busy_fall, 2);
        check("irq_byte", log_at(n0), 8'h66);

        // Reset in WAIT_DONE with two bytes queued
        busy_len = 30;
        n0 = n_strobe;
        wr(A_TX, 8'h71);
        wr(A_TX, 8'h72);
        wr(A_TX, 8'h73);
        repeat (4) tick();
        check("pre_rst_busy", uart_busy, 1'b1);
        nRst = 1'b0;
        #1;
        check("mid_rst_utx", uart_transmit, 1'b0);
        check("mid_rst_udata", uart_data, 8'h00);
        check("mid_rst_gpo", gpo, 16'h0000);
        check("mid_rst_irq", irq, 1'b0);
        check("mid_rst_rdata", rdata, 8'h00);
        repeat (2) @(posedge clk);
        tick();
        nRst = 1'b1;
        rd(A_ST, v);   check("post_rst_status", v, ST_IDLE | ST_EMPTY);
        rd(A_CTRL, v); check("post_rst_ctrl", v, 8'h00);
        repeat (60) tick();
        check("post_rst_strobes", n_strobe, n0 + 1);
        check("strobe_width", long_strb, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
